// File: rtl/ma_sram_ctrl_if.sv
// Bundles the MA-stage request side and the SRAM pin side of the data-memory controller.
// Latency: none, wires only.
// Backpressure: carried by ready; the requester holds its inputs while ready is low.
interface ma_sram_ctrl_if #(
  parameter int SRAM_AW = 18
);

  // Pipeline side
  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        address;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;

  // SRAM side
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic [15:0]        sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;
  logic               sram_oe_n;

  // Environment view: the MA stage issuing requests plus the SRAM returning read data.
  modport master (
    output mem_r_en,
    output mem_w_en,
    output address,
    output wdata,
    output sram_dq_in,
    input  rdata,
    input  ready,
    input  sram_addr,
    input  sram_dq_out,
    input  sram_dq_oe,
    input  sram_we_n,
    input  sram_oe_n
  );

  // Controller view.
  modport slave (
    input  mem_r_en,
    input  mem_w_en,
    input  address,
    input  wdata,
    input  sram_dq_in,
    output rdata,
    output ready,
    output sram_addr,
    output sram_dq_out,
    output sram_dq_oe,
    output sram_we_n,
    output sram_oe_n
  );

endinterface

// File: rtl/ma_sram_ctrl.sv
// Splits each 32-bit MA-stage load/store into two 16-bit async SRAM cycles, low half first.
// Latency: ready rises 2*WAIT_CYCLES+1 cycles after a request is seen in IDLE.
// Backpressure: ready stays low for the whole access; requests are only accepted in IDLE.
module ma_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  ma_sram_ctrl_if.slave bus
);

  // The wait counter is 4 bits wide, so longer phases cannot be expressed.
  if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("ma_sram_ctrl: WAIT_CYCLES must be within 2..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [15:0]        wdata_hi_q, wdata_hi_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               dq_oe_q, dq_oe_d;

  logic               req;
  logic               last;
  logic               phase_d;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word_sel;
  logic               unused_offset_bits;

  assign req      = bus.mem_r_en | bus.mem_w_en;
  assign last     = (cnt_q == LAST);

  // Byte offset into data memory; the word index drops the byte lane and any bits
  // beyond the SRAM reach.
  assign offset   = bus.address - BASE;
  assign word_sel = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // Next-state, counter, latched request and data-path updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    word_d     = word_q;
    wdata_hi_d = wdata_hi_q;
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = LO;
          cnt_d      = 4'd0;
          // A simultaneous read+write request is treated as a store.
          wr_d       = bus.mem_w_en;
          word_d     = word_sel;
          wdata_hi_d = bus.wdata[31:16];
          addr_d     = {word_sel, 1'b0};
          dq_out_d   = bus.wdata[15:0];
        end
      end
      LO: begin
        if (last) begin
          state_d  = HI;
          cnt_d    = 4'd0;
          addr_d   = {word_q, 1'b1};
          dq_out_d = wdata_hi_q;
          if (!wr_q) begin
            rdata_d[15:0] = bus.sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          if (!wr_q) begin
            rdata_d[31:16] = bus.sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM strobes are computed one cycle ahead so the pins come straight from flops.
  // The final cycle of a write phase keeps address/data stable with we_n released.
  always_comb begin
    phase_d = (state_d == LO) || (state_d == HI);
    dq_oe_d = phase_d & wr_d;
    oe_n_d  = ~(phase_d & ~wr_d);
    we_n_d  = ~(phase_d & wr_d & (cnt_d != LAST));
  end

  // State and data-path registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= 16'd0;
      addr_q     <= '0;
      dq_out_q   <= 16'd0;
      rdata_q    <= 32'd0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      word_q     <= word_d;
      wdata_hi_q <= wdata_hi_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      rdata_q    <= rdata_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  // Ready is combinational so an idle cycle without a request never stalls the pipe.
  always_comb begin
    bus.ready = ((state_q == IDLE) && !req) || (state_q == DONE);
  end

  assign bus.rdata       = rdata_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_ma_sram_ctrl.sv
// Directed bench for ma_sram_ctrl with a 64-half-word SRAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Cycle 0 is the first cycle in which a request is presented in IDLE.
module tb_ma_sram_ctrl;

  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ma_sram_ctrl_if #(.SRAM_AW(AW)) bus();

  ma_sram_ctrl #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(2),
    .SRAM_AW    (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM model: write on a clock edge while we_n is low and the controller drives dq.
  logic [15:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_a  = 6'd0;
  logic [15:0] pre_d  = 16'd0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!bus.sram_we_n && bus.sram_dq_oe) mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
  end

  assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0000 : mem[bus.sram_addr[5:0]];

  task automatic preload(input logic [5:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic test_reset;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.address = 32'd0; bus.wdata = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready c%0d: got %b want 1", c, bus.ready); end
      n_cmp++; if (bus.sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n c%0d: got %b want 1", c, bus.sram_we_n); end
      n_cmp++; if (bus.sram_oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_oe_n c%0d: got %b want 1", c, bus.sram_oe_n); end
      n_cmp++; if (bus.sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dq_oe c%0d: got %b want 0", c, bus.sram_dq_oe); end
      n_cmp++; if (bus.rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata c%0d: got %h want 0", c, bus.rdata); end
      n_cmp++; if (bus.sram_addr !== '0) begin n_bad++; $display("FAIL reset_addr c%0d: got %h want 0", c, bus.sram_addr); end
    end
  endtask

  task automatic test_load;
    logic [AW-1:0] exp_a;
    preload(6'd0, 16'h1234);
    preload(6'd1, 16'hABCD);
    @(posedge clk); #1;
    bus.address = 32'd1024; bus.mem_r_en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.ready !== (c == 5)) begin n_bad++; $display("FAIL load_ready c%0d: got %b want %b", c, bus.ready, (c == 5)); end
      n_cmp++; if (bus.sram_oe_n !== !(c >= 1 && c <= 4)) begin n_bad++; $display("FAIL load_oe_n c%0d: got %b", c, bus.sram_oe_n); end
      n_cmp++; if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL load_no_drive c%0d: we_n %b dq_oe %b want 1/0", c, bus.sram_we_n, bus.sram_dq_oe); end
      if (c >= 1 && c <= 4) begin
        exp_a = (c <= 2) ? 18'd0 : 18'd1;
        n_cmp++; if (bus.sram_addr !== exp_a) begin n_bad++; $display("FAIL load_addr c%0d: got %0d want %0d", c, bus.sram_addr, exp_a); end
      end
      if (c == 5) begin
        n_cmp++; if (bus.rdata !== 32'hABCD1234) begin n_bad++; $display("FAIL load_rdata: got %h want abcd1234", bus.rdata); end
      end
    end
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL load_idle_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.rdata !== 32'hABCD1234) begin n_bad++; $display("FAIL load_rdata_hold: got %h want abcd1234", bus.rdata); end
  endtask

  task automatic test_store;
    logic [15:0] exp_d;
    logic [AW-1:0] exp_a;
    @(posedge clk); #1;
    bus.address = 32'd1028; bus.wdata = 32'hDEADBEEF; bus.mem_w_en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.ready !== (c == 5)) begin n_bad++; $display("FAIL store_ready c%0d: got %b want %b", c, bus.ready, (c == 5)); end
      n_cmp++; if (bus.sram_we_n !== !(c == 1 || c == 3)) begin n_bad++; $display("FAIL store_we_n c%0d: got %b", c, bus.sram_we_n); end
      n_cmp++; if (bus.sram_dq_oe !== (c >= 1 && c <= 4)) begin n_bad++; $display("FAIL store_dq_oe c%0d: got %b", c, bus.sram_dq_oe); end
      n_cmp++; if (bus.sram_oe_n !== 1'b1) begin n_bad++; $display("FAIL store_oe_n c%0d: got %b want 1", c, bus.sram_oe_n); end
      if (c >= 1 && c <= 4) begin
        exp_d = (c <= 2) ? 16'hBEEF : 16'hDEAD;
        exp_a = (c <= 2) ? 18'd2 : 18'd3;
        n_cmp++; if (bus.sram_dq_out !== exp_d) begin n_bad++; $display("FAIL store_dq_out c%0d: got %h want %h", c, bus.sram_dq_out, exp_d); end
        n_cmp++; if (bus.sram_addr !== exp_a) begin n_bad++; $display("FAIL store_addr c%0d: got %0d want %0d", c, bus.sram_addr, exp_a); end
      end
    end
    @(posedge clk); #1;
    bus.mem_w_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem[2] !== 16'hBEEF) begin n_bad++; $display("FAIL store_mem2: got %h want beef", mem[2]); end
    n_cmp++; if (mem[3] !== 16'hDEAD) begin n_bad++; $display("FAIL store_mem3: got %h want dead", mem[3]); end
    n_cmp++; if (bus.rdata !== 32'hABCD1234) begin n_bad++; $display("FAIL store_rdata_hold: got %h want abcd1234", bus.rdata); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    bus.address = 32'd1032; bus.wdata = 32'hCAFEF00D; bus.mem_w_en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.ready !== (c == 5)) begin n_bad++; $display("FAIL b2b_st_ready c%0d: got %b want %b", c, bus.ready, (c == 5)); end
    end
    // Load presented in the cycle right after DONE (cycle 6, IDLE).
    @(posedge clk); #1;
    bus.mem_w_en = 1'b0; bus.mem_r_en = 1'b1;
    for (int c = 6; c <= 11; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.ready !== (c == 11)) begin n_bad++; $display("FAIL b2b_ld_ready c%0d: got %b want %b", c, bus.ready, (c == 11)); end
      if (c == 6) begin
        n_cmp++; if (bus.sram_oe_n !== 1'b1 || bus.sram_we_n !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_strobes: oe_n %b we_n %b want 1/1", bus.sram_oe_n, bus.sram_we_n); end
      end
      if (c == 11) begin
        n_cmp++; if (bus.rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_rdata: got %h want cafef00d", bus.rdata); end
      end
    end
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem[4] !== 16'hF00D || mem[5] !== 16'hCAFE) begin n_bad++; $display("FAIL b2b_mem: got %h_%h want cafe_f00d", mem[5], mem[4]); end
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1;
    bus.address = 32'd1048; bus.wdata = 32'h0F0F0F0F;
    bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.sram_oe_n !== 1'b1) begin n_bad++; $display("FAIL simul_oe_n c%0d: got %b want 1", c, bus.sram_oe_n); end
      n_cmp++; if (bus.sram_dq_oe !== (c >= 1 && c <= 4)) begin n_bad++; $display("FAIL simul_dq_oe c%0d: got %b", c, bus.sram_dq_oe); end
      n_cmp++; if (bus.ready !== (c == 5)) begin n_bad++; $display("FAIL simul_ready c%0d: got %b want %b", c, bus.ready, (c == 5)); end
    end
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem[12] !== 16'h0F0F || mem[13] !== 16'h0F0F) begin n_bad++; $display("FAIL simul_mem: got %h_%h want 0f0f_0f0f", mem[13], mem[12]); end
    n_cmp++; if (bus.rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL simul_rdata: got %h want cafef00d", bus.rdata); end
  endtask

  task automatic test_reset_mid;
    preload(6'd16, 16'h5555);
    preload(6'd17, 16'h5555);
    @(posedge clk); #1;
    bus.address = 32'd1056; bus.wdata = 32'h22221111; bus.mem_w_en = 1'b1;
    // Advance to cycle 3: first cycle of HI, write strobe active.
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.sram_we_n !== 1'b0 || bus.sram_addr !== 18'd17) begin n_bad++; $display("FAIL midrst_pre: we_n %b addr %0d want 0/17", bus.sram_we_n, bus.sram_addr); end
    #1 rst_n = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    n_cmp++; if (bus.sram_we_n !== 1'b1) begin n_bad++; $display("FAIL midrst_we_n: got %b want 1", bus.sram_we_n); end
    n_cmp++; if (bus.sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL midrst_dq_oe: got %b want 0", bus.sram_dq_oe); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL midrst_idle_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.rdata !== 32'd0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", bus.rdata); end
    n_cmp++; if (bus.sram_addr !== '0) begin n_bad++; $display("FAIL midrst_addr: got %h want 0", bus.sram_addr); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem[16] !== 16'h1111) begin n_bad++; $display("FAIL midrst_mem_lo: got %h want 1111", mem[16]); end
    n_cmp++; if (mem[17] !== 16'h5555) begin n_bad++; $display("FAIL midrst_mem_hi: got %h want 5555", mem[17]); end
    n_cmp++; if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1) begin n_bad++; $display("FAIL midrst_after: ready %b we_n %b want 1/1", bus.ready, bus.sram_we_n); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
